// File: rtl/fencei_controller.sv
// FENCE.I sequencer: holds the front end, drains stores, optionally writes back the D-cache,
// invalidates the I-cache and redirects fetch to the instruction after the FENCE.I.
module fencei_controller #(
    parameter int XLEN           = 32,
    parameter bit HAS_DCACHE     = 1'b1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fencei_valid,
    input  logic [XLEN-1:0] fencei_pc,
    input  logic            kill,
    input  logic            sb_empty,
    output logic            dc_flush_req,
    input  logic            dc_flush_ack,
    output logic            ic_inv_req,
    input  logic            ic_inv_done,
    output logic            stall,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy,
    output logic            timeout_err
);

    localparam int            TW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DRAIN     = 3'd1,
        S_DFLUSH    = 3'd2,
        S_IINV_REQ  = 3'd3,
        S_IINV_WAIT = 3'd4,
        S_REDIRECT  = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            killed_q, killed_d;
    logic            done_seen_q, done_seen_d;
    logic            timer_hit_s;
    logic            timeout_s;
    logic            counting_s;

    // State, captured PC, wait timer and sticky kill/done flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            timer_q     <= '0;
            killed_q    <= 1'b0;
            done_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            timer_q     <= timer_d;
            killed_q    <= killed_d;
            done_seen_q <= done_seen_d;
        end
    end

    // Next-state logic; a kill after DRAIN only suppresses the final redirect
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        killed_d    = killed_q;
        done_seen_d = done_seen_q;
        timeout_s   = 1'b0;
        timer_hit_s = (timer_q == TMAX);
        case (state_q)
            S_IDLE: begin
                if (fencei_valid && !kill) begin
                    state_d     = S_DRAIN;
                    pc_d        = fencei_pc;
                    killed_d    = 1'b0;
                    done_seen_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else if (sb_empty || timer_hit_s) begin
                    timeout_s = !sb_empty;
                    state_d   = HAS_DCACHE ? S_DFLUSH : S_IINV_REQ;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DFLUSH: begin
                killed_d = killed_q | kill;
                if (dc_flush_ack || timer_hit_s) begin
                    timeout_s = !dc_flush_ack;
                    state_d   = S_IINV_REQ;
                end else begin
                    state_d = S_DFLUSH;
                end
            end
            S_IINV_REQ: begin
                killed_d    = killed_q | kill;
                done_seen_d = ic_inv_done;
                state_d     = S_IINV_WAIT;
            end
            S_IINV_WAIT: begin
                killed_d = killed_q | kill;
                if (ic_inv_done || done_seen_q || timer_hit_s) begin
                    timeout_s = !(ic_inv_done || done_seen_q);
                    state_d   = (killed_q || kill) ? S_IDLE : S_REDIRECT;
                end else begin
                    state_d = S_IINV_WAIT;
                end
            end
            S_REDIRECT: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Wait timer: restarts on every state change and saturates at the limit
    always_comb begin
        counting_s = (state_q == S_DRAIN) || (state_q == S_DFLUSH) || (state_q == S_IINV_WAIT);
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (counting_s && !timer_hit_s) begin
            timer_d = timer_q + TW'(1);
        end else begin
            timer_d = timer_q;
        end
    end

    // Outputs decoded from the state register; stall also covers the accept cycle
    always_comb begin
        busy           = (state_q != S_IDLE);
        stall          = busy | (fencei_valid & ~kill);
        dc_flush_req   = (state_q == S_DFLUSH);
        ic_inv_req     = (state_q == S_IINV_REQ);
        redirect_valid = (state_q == S_REDIRECT) & ~kill;
        redirect_pc    = redirect_valid ? (pc_q + XLEN'(4)) : '0;
        timeout_err    = timeout_s;
    end

endmodule

// File: tb/tb_fencei_controller.sv
// Directed bench for fencei_controller: table-driven vectors plus hand-written
// sequences for timeout, no-D-cache wrap-around and asynchronous reset.
module tb_fencei_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        fencei_valid, kill, sb_empty, dc_flush_ack, ic_inv_done;
    logic [31:0] fencei_pc;

    logic        a_dfr, a_ici, a_stall, a_rv, a_busy, a_te;
    logic [31:0] a_rpc;
    logic        b_dfr, b_ici, b_stall, b_rv, b_busy, b_te;
    logic [31:0] b_rpc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fencei_controller #(.XLEN(32), .HAS_DCACHE(1'b1), .TIMEOUT_CYCLES(8)) u_a (
        .clk(clk), .reset(reset), .fencei_valid(fencei_valid), .fencei_pc(fencei_pc),
        .kill(kill), .sb_empty(sb_empty), .dc_flush_req(a_dfr), .dc_flush_ack(dc_flush_ack),
        .ic_inv_req(a_ici), .ic_inv_done(ic_inv_done), .stall(a_stall),
        .redirect_valid(a_rv), .redirect_pc(a_rpc), .busy(a_busy), .timeout_err(a_te)
    );

    fencei_controller #(.XLEN(32), .HAS_DCACHE(1'b0), .TIMEOUT_CYCLES(8)) u_b (
        .clk(clk), .reset(reset), .fencei_valid(fencei_valid), .fencei_pc(fencei_pc),
        .kill(kill), .sb_empty(sb_empty), .dc_flush_req(b_dfr), .dc_flush_ack(dc_flush_ack),
        .ic_inv_req(b_ici), .ic_inv_done(ic_inv_done), .stall(b_stall),
        .redirect_valid(b_rv), .redirect_pc(b_rpc), .busy(b_busy), .timeout_err(b_te)
    );

    typedef struct {
        logic        fv;
        logic [31:0] pc;
        logic        kl, sb, ack, done;
        logic        e_stall, e_busy, e_dfr, e_ici, e_rv;
        logic [31:0] e_rpc;
        logic        e_te;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic fv, input logic [31:0] pc, input logic kl,
                               input logic sb, input logic ack, input logic done,
                               input logic st, input logic bz, input logic dfr,
                               input logic ici, input logic rv, input logic [31:0] rpc,
                               input logic te);
        vec_t r;
        r.fv = fv; r.pc = pc; r.kl = kl; r.sb = sb; r.ack = ack; r.done = done;
        r.e_stall = st; r.e_busy = bz; r.e_dfr = dfr; r.e_ici = ici;
        r.e_rv = rv; r.e_rpc = rpc; r.e_te = te;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic [31:0] pc, input logic kl,
                         input logic sb, input logic ack, input logic done);
        fencei_valid = fv;
        fencei_pc    = pc;
        kill         = kl;
        sb_empty     = sb;
        dc_flush_ack = ack;
        ic_inv_done  = done;
    endtask

    task automatic check_a_idle(input string tag);
        check({tag, "_stall"}, {31'd0, a_stall}, 32'd0);
        check({tag, "_busy"},  {31'd0, a_busy},  32'd0);
        check({tag, "_dfr"},   {31'd0, a_dfr},   32'd0);
        check({tag, "_ici"},   {31'd0, a_ici},   32'd0);
        check({tag, "_rv"},    {31'd0, a_rv},    32'd0);
        check({tag, "_rpc"},   a_rpc,            32'd0);
        check({tag, "_te"},    {31'd0, a_te},    32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check_a_idle("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int seen;
        int dfr_seen;
        int rv_cycle;

        // Test 1: best case, pc 0x100
        tbl.push_back(v(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0));
        tbl.push_back(v(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0));
        tbl.push_back(v(1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0));
        tbl.push_back(v(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0));
        tbl.push_back(v(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0));
        tbl.push_back(v(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h104, 1'b0));
        tbl.push_back(v(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0));
        // Test 2: store buffer busy, DRAIN lasts 7 cycles
        tbl.push_back(v(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0));
        for (int i = 0; i < 6; i++)
            tbl.push_back(v(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
        tbl.push_back(v(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0));
        tbl.push_back(v(1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0));
        tbl.push_back(v(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0));
        tbl.push_back(v(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0));
        tbl.push_back(v(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h204, 1'b0));
        tbl.push_back(v(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0));
        // Test 3a: valid with kill ignored, then kill in DRAIN aborts
        tbl.push_back(v(1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0));
        tbl.push_back(v(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0));
        tbl.push_back(v(1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0));
        tbl.push_back(v(1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0));
        // Test 3b: kill in DFLUSH, handshakes complete, no redirect
        tbl.push_back(v(1'b1, 32'h400, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0));
        tbl.push_back(v(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0));
        tbl.push_back(v(1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0));
        tbl.push_back(v(1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0));
        tbl.push_back(v(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0));
        tbl.push_back(v(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0));
        tbl.push_back(v(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0));
        // Kill in the REDIRECT cycle suppresses redirect_valid
        tbl.push_back(v(1'b1, 32'h500, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0));
        tbl.push_back(v(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0));
        tbl.push_back(v(1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0));
        tbl.push_back(v(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0));
        tbl.push_back(v(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0));
        tbl.push_back(v(1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0));
        tbl.push_back(v(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0));

        do_reset();
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].fv, tbl[i].pc, tbl[i].kl, tbl[i].sb, tbl[i].ack, tbl[i].done);
            #1;
            check($sformatf("row%0d_stall", i), {31'd0, a_stall}, {31'd0, tbl[i].e_stall});
            check($sformatf("row%0d_busy", i),  {31'd0, a_busy},  {31'd0, tbl[i].e_busy});
            check($sformatf("row%0d_dfr", i),   {31'd0, a_dfr},   {31'd0, tbl[i].e_dfr});
            check($sformatf("row%0d_ici", i),   {31'd0, a_ici},   {31'd0, tbl[i].e_ici});
            check($sformatf("row%0d_rv", i),    {31'd0, a_rv},    {31'd0, tbl[i].e_rv});
            check($sformatf("row%0d_rpc", i),   a_rpc,            tbl[i].e_rpc);
            check($sformatf("row%0d_te", i),    {31'd0, a_te},    {31'd0, tbl[i].e_te});
        end

        // Test 4: ack never arrives, timeout on the 8th DFLUSH cycle
        do_reset();
        @(negedge clk); drive(1'b1, 32'h600, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("to_dfr%0d", i), {31'd0, a_dfr}, 32'd1);
            check($sformatf("to_te%0d", i),  {31'd0, a_te},  (i == 8) ? 32'd1 : 32'd0);
        end
        @(negedge clk); drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        check("to_req_drop", {31'd0, a_dfr}, 32'd0);
        check("to_ici",      {31'd0, a_ici}, 32'd1);
        check("to_te_once",  {31'd0, a_te},  32'd0);
        @(negedge clk); drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check("to_wait_busy", {31'd0, a_busy}, 32'd1);
        @(negedge clk); #1;
        check("to_rv",  {31'd0, a_rv}, 32'd1);
        check("to_rpc", a_rpc, 32'h604);
        @(negedge clk); #1;
        check("to_end_stall", {31'd0, a_stall}, 32'd0);

        // Test 5: no D-cache, PC wraps to zero
        do_reset();
        seen = 0; dfr_seen = 0; rv_cycle = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 1'b1);
            else        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
            #1;
            if (b_dfr) dfr_seen = 1;
            if (b_rv && seen == 0) begin
                seen = 1;
                rv_cycle = c;
                check("nodc_rpc", b_rpc, 32'h0);
            end
        end
        check("nodc_rv_seen",   seen,     32'd1);
        check("nodc_rv_cycle",  rv_cycle, 32'd4);
        check("nodc_dfr_never", dfr_seen, 32'd0);

        // Test 6: asynchronous reset while waiting for invalidate
        do_reset();
        @(negedge clk); drive(1'b1, 32'h680, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk); drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); #1;
        check("ar_wait_busy", {31'd0, a_busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check_a_idle("ar_async");
        @(negedge clk); reset = 1'b0;
        rv_cycle = -1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 0) drive(1'b1, 32'h700, 1'b0, 1'b1, 1'b1, 1'b1);
            else        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
            #1;
            if (a_rv && rv_cycle < 0) begin
                rv_cycle = c;
                check("ar_rpc", a_rpc, 32'h704);
            end
        end
        check("ar_rv_cycle", rv_cycle, 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
